// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter, instruction register and bounded-wait instruction fetch for the multicycle core
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             pc_write_i,
  input  logic             pc_write_cond_i,
  input  logic [1:0]       pc_source_i,
  input  logic             ir_write_i,
  input  logic [31:0]      alu_result_i,
  input  logic [31:0]      alu_out_reg_i,
  input  logic             alu_zero_i,
  output logic             mem_req_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      ir_o,
  output logic [5:0]       opcode_o,
  output logic [4:0]       rs_o,
  output logic [4:0]       rt_o,
  output logic [4:0]       rd_o,
  output logic [5:0]       funct_o,
  output logic [31:0]      imm_sext_o,
  output logic             ir_valid_o,
  output logic             fetch_busy_o,
  output logic             halted_o,
  output logic             bus_error_o,
  output logic             fetch_overrun_o,
  output logic [CNT_W-1:0] retired_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [0:0]       state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d, ir_q, ir_d, addr_q, addr_d, pc_nxt;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             ir_valid_q, ir_valid_d, halted_q, halted_d;
  logic             bus_err_q, bus_err_d, overrun_q, overrun_d;
  logic             pc_en, start, ack, tmo, waiting;
  always_comb begin
    waiting    = state_q == WAIT;
    start      = !waiting && ir_write_i;
    ack        = waiting && mem_ack_i;
    // ack takes priority over a timeout landing in the same cycle
    tmo        = waiting && !mem_ack_i && cnt_q == TW'(TIMEOUT - 1);
    pc_en      = (pc_write_i || (pc_write_cond_i && alu_zero_i)) && !halted_q;
    pc_nxt     = pc_source_i == 2'b00 ? alu_result_i :
                 pc_source_i == 2'b01 ? alu_out_reg_i :
                 pc_source_i == 2'b10 ? {pc_q[31:28], ir_q[25:0], 2'b00} : pc_q;
    pc_d       = pc_en ? pc_nxt : pc_q;
    ret_d      = pc_en ? ret_q + CNT_W'(1) : ret_q;
    state_d    = start ? WAIT : (ack || tmo) ? IDLE : state_q;
    cnt_d      = start ? '0 : waiting ? cnt_q + TW'(1) : cnt_q;
    addr_d     = start ? pc_q : addr_q;
    ir_d       = ack ? mem_rdata_i : ir_q;
    ir_valid_d = start ? 1'b0 : ack ? 1'b1 : ir_valid_q;
    halted_d   = halted_q || (ack && &mem_rdata_i[31:26]);
    bus_err_d  = bus_err_q || tmo;
    overrun_d  = overrun_q || (waiting && ir_write_i);
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      addr_q     <= '0;
      ret_q      <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      addr_q     <= addr_d;
      ret_q      <= ret_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      bus_err_q  <= bus_err_d;
      overrun_q  <= overrun_d;
    end
  end
  assign mem_req_o       = state_q == WAIT;
  assign fetch_busy_o    = state_q != IDLE;
  assign mem_addr_o      = addr_q;
  assign pc_o            = pc_q;
  assign ir_o            = ir_q;
  assign opcode_o        = ir_q[31:26];
  assign rs_o            = ir_q[25:21];
  assign rt_o            = ir_q[20:16];
  assign rd_o            = ir_q[15:11];
  assign funct_o         = ir_q[5:0];
  assign imm_sext_o      = {{16{ir_q[15]}}, ir_q[15:0]};
  assign ir_valid_o      = ir_valid_q;
  assign halted_o        = halted_q;
  assign bus_error_o     = bus_err_q;
  assign fetch_overrun_o = overrun_q;
  assign retired_o       = ret_q;
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Owns the program counter and instruction register of the multicycle core, and sits directly upstream of the control unit. It supplies opCode and the decoded instruction fields. It applies the control unit's PCWrite/PCWriteCond/PCSource/IRWrite strobes and fetches instructions over a req/ack memory port with a bounded wait. It also detects the END opcode and halts PC updates.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles to wait for mem_ack before aborting a fetch (>=1)
CNT_W, 16, width of retired-PC-update counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
pc_write  in  1  unconditional PC update strobe
pc_write_cond  in  1  PC update qualified by alu_zero
pc_source  in  2  next-PC select
ir_write  in  1  one-cycle pulse requesting an instruction fetch at current PC
alu_result  in  32  live ALU output (PC+4 path)
alu_out_reg  in  32  registered ALU output (branch target path)
alu_zero  in  1  ALU zero flag
mem_req  out  1  fetch request, held until mem_ack or timeout
mem_addr  out  32  fetch address, stable while mem_req=1
mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in same cycle
mem_rdata  in  32  instruction word
pc  out  32  current PC
ir  out  32  instruction register
opcode  out  6  ir[31:26]
rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11]
funct  out  6  ir[5:0]
imm_sext  out  32  sign-extended ir[15:0]
ir_valid  out  1  ir holds a successfully fetched word
fetch_busy  out  1  fetch FSM not IDLE (stall hint to control unit)
halted  out  1  END opcode (6'b111111) has been latched
bus_error  out  1  sticky: a fetch timed out
fetch_overrun  out  1  sticky: ir_write arrived while fetch_busy
retired  out  CNT_W  count of PC updates applied, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, any state): pc=RESET_PC; ir=0; ir_valid=0; mem_req=0; mem_addr=0; fetch_busy=0; halted=0; bus_error=0; fetch_overrun=0; retired=0; FSM=IDLE. A fetch aborted mid-wait by reset is discarded; a late mem_ack after reset is ignored while IDLE.
- PC update enable: pc_en = (pc_write | (pc_write_cond & alu_zero)) & ~halted.
- Next PC by pc_source: 00 alu_result; 01 alu_out_reg; 10 {pc[31:28], ir[25:0], 2'b00}; 11 pc (hold, but still counts as update).
- pc_en: pc <= next PC at the clock edge; retired <= retired+1 (wraps).
- PC writes are accepted while a fetch is pending. mem_addr stays the address captured at request start.
- Fetch FSM states:
  - IDLE: on ir_write, go to WAIT; mem_req<=1; mem_addr<=pc; wait counter<=0; ir_valid<=0.
  - WAIT: each cycle without mem_ack, counter increments.
    - mem_ack: ir<=mem_rdata; ir_valid<=1; mem_req<=0; go to IDLE.
    - If opcode of mem_rdata == 6'b111111: halted<=1 (sticky until reset).
    - No mem_ack and counter reaches TIMEOUT-1: mem_req<=0; bus_error<=1; ir unchanged; ir_valid stays 0; go to IDLE.
- Fetch latency: request issued the cycle after ir_write. IR updates at the edge where mem_ack=1, so minimum latency is 2 cycles from ir_write to ir_valid.
- fetch_busy = (FSM != IDLE), combinational.
- ir_write while in WAIT: ignored; fetch_overrun<=1.
- mem_ack and timeout in the same cycle: ack wins.
- mem_ack while IDLE: ignored.
- halted: blocks pc_en only. Fetches still complete, so the END word remains visible in ir.
- Decoded field outputs are combinational from ir.

Test Plan:
- Reset, then ir_write with mem_ack 2 cycles later, rdata=32'h2008_0005 -> mem_addr=0; ir=32'h2008_0005; opcode=6'b001000; imm_sext=5; ir_valid=1; fetch_busy low after ack.
- pc_write=1, pc_source=00, alu_result=4 -> pc=4, retired=1. pc_write_cond=1, alu_zero=0 -> pc unchanged. Then alu_zero=1, pc_source=01, alu_out_reg=32'h40 -> pc=32'h40, retired=2.
- pc=32'h1000_0000, ir=32'h0800_0010, pc_write with pc_source=10 -> pc=32'h1000_0040.
- TIMEOUT=16, ir_write, no ack -> mem_req deasserts after 16 cycles; bus_error=1; ir_valid=0. A second ir_write during the wait -> fetch_overrun=1 and mem_addr unchanged.
- Fetch returns 32'hFC00_0000 -> halted=1. A subsequent pc_write is ignored and retired is unchanged. Async reset mid-cycle -> all outputs at reset values before the next edge.
- CNT_W=4 with 17 PC updates -> retired=1 (wrap).
